// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART slice: FSM state encoding,
// default parameter values and a width helper for the internal counters.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 163;
    localparam int DEF_FIFO_W  = 2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO with registered full/empty flags and first-word
// fall-through read data. Storage is cleared on reset.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int B = DEF_DBIT,
    parameter int W = DEF_FIFO_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH = 1 << W;

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_succ;
    logic [W-1:0] r_ptr_succ;
    logic         do_wr;
    logic         do_rd;

    // A write into a full buffer is accepted only when the head leaves in
    // the same clock; the freed slot is the one being written.
    always_comb begin
        do_rd      = rd && !empty;
        do_wr      = wr && (!full || rd);
        w_ptr_succ = w_ptr + 1'b1;
        r_ptr_succ = r_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[W-1:0]] <= '0;
            end
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_wr) begin
                mem[w_ptr] <= w_data;
                w_ptr      <= w_ptr_succ;
            end
            if (do_rd) begin
                r_ptr <= r_ptr_succ;
            end
            if (do_wr && !do_rd) begin
                empty <= 1'b0;
                full  <= (w_ptr_succ == r_ptr);
            end else if (do_rd && !do_wr) begin
                full  <= 1'b0;
                empty <= (r_ptr_succ == w_ptr);
            end
        end
    end

    assign r_data = mem[r_ptr];

endmodule

// File: rtl/uart.sv
// Full-duplex UART: shared 16x oversampling baud tick, receiver and
// transmitter FSMs, and a small FIFO on each direction.
module uart
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR,
    parameter int FIFO_W  = DEF_FIFO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr,
    output logic            full,
    output logic            tx,
    input  logic            rx,
    input  logic            rd,
    output logic [DBIT-1:0] r_data,
    output logic            empty
);

    localparam int CW = width_of(DVSR);
    localparam int SW = (width_of(SB_TICK) > 4) ? width_of(SB_TICK) : 4;
    localparam int NW = width_of(DBIT);

    // Baud generator
    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == CW'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // Receiver
    state_t          rx_state, rx_state_next;
    logic [SW-1:0]   rx_s, rx_s_next;
    logic [NW-1:0]   rx_n, rx_n_next;
    logic [DBIT-1:0] rx_b, rx_b_next;
    logic            rx_done;
    logic            rx_fifo_full;
    logic            rx_fifo_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state <= IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_s     <= rx_s_next;
            rx_n     <= rx_n_next;
            rx_b     <= rx_b_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_s_next     = rx_s;
        rx_n_next     = rx_n;
        rx_b_next     = rx_b;
        rx_done       = 1'b0;
        unique case (rx_state)
            IDLE: begin
                if (!rx) begin
                    rx_state_next = START;
                    rx_s_next     = '0;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (tick) begin
                    if (rx_s == SW'(7)) begin
                        if (!rx) begin
                            rx_state_next = DATA;
                            rx_s_next     = '0;
                            rx_n_next     = '0;
                        end else begin
                            rx_state_next = IDLE;
                        end
                    end else begin
                        rx_s_next = rx_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s == SW'(15)) begin
                        rx_s_next = '0;
                        rx_b_next = {rx, rx_b[DBIT-1:1]};
                        if (rx_n == NW'(DBIT - 1)) begin
                            rx_state_next = STOP;
                        end else begin
                            rx_n_next = rx_n + 1'b1;
                        end
                    end else begin
                        rx_s_next = rx_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s == SW'(SB_TICK - 1)) begin
                        rx_state_next = IDLE;
                        rx_done       = 1'b1;
                    end else begin
                        rx_s_next = rx_s + 1'b1;
                    end
                end
            end
        endcase
    end

    // A byte arriving on a full RX FIFO is dropped unless the host frees a slot
    // in the same clock.
    assign rx_fifo_wr = rx_done && (!rx_fifo_full || rd);

    uart_fifo #(
        .B(DBIT),
        .W(FIFO_W)
    ) rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (rx_fifo_wr),
        .w_data (rx_b),
        .r_data (r_data),
        .full   (rx_fifo_full),
        .empty  (empty)
    );

    // Transmitter
    state_t          tx_state, tx_state_next;
    logic [SW-1:0]   tx_s, tx_s_next;
    logic [NW-1:0]   tx_n, tx_n_next;
    logic [DBIT-1:0] tx_b, tx_b_next;
    logic            tx_reg, tx_next;
    logic            tx_fifo_rd;
    logic            tx_fifo_empty;
    logic [DBIT-1:0] tx_fifo_dout;

    uart_fifo #(
        .B(DBIT),
        .W(FIFO_W)
    ) tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_fifo_rd),
        .wr     (wr),
        .w_data (w_data),
        .r_data (tx_fifo_dout),
        .full   (full),
        .empty  (tx_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_reg   <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_s     <= tx_s_next;
            tx_n     <= tx_n_next;
            tx_b     <= tx_b_next;
            tx_reg   <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_s_next     = tx_s;
        tx_n_next     = tx_n;
        tx_b_next     = tx_b;
        tx_next       = 1'b1;
        tx_fifo_rd    = 1'b0;
        unique case (tx_state)
            IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_fifo_rd    = 1'b1;
                    tx_b_next     = tx_fifo_dout;
                    tx_s_next     = '0;
                    tx_state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (tick) begin
                    if (tx_s == SW'(15)) begin
                        tx_state_next = DATA;
                        tx_s_next     = '0;
                        tx_n_next     = '0;
                    end else begin
                        tx_s_next = tx_s + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_next = tx_b[0];
                if (tick) begin
                    if (tx_s == SW'(15)) begin
                        tx_s_next = '0;
                        tx_b_next = tx_b >> 1;
                        if (tx_n == NW'(DBIT - 1)) begin
                            tx_state_next = STOP;
                        end else begin
                            tx_n_next = tx_n + 1'b1;
                        end
                    end else begin
                        tx_s_next = tx_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_s == SW'(SB_TICK - 1)) begin
                        tx_state_next = IDLE;
                    end else begin
                        tx_s_next = tx_s + 1'b1;
                    end
                end
            end
        endcase
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: host-side tables, a serial TX decoder and
// a bit-level RX driver, with expected bytes held in scoreboard queues.
module tb_uart;

    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int DVSR       = 6;
    localparam int FIFO_W     = 2;
    localparam int BIT_CLKS   = 16 * DVSR;
    localparam int FRAME_CLKS = (1 + DBIT) * 16 * DVSR + SB_TICK * DVSR;

    typedef struct {
        logic [7:0] data;
        logic       exp_flag;
        logic       kept;
    } vec_t;

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic            wr      = 1'b0;
    logic            rd      = 1'b0;
    logic            rx_drv  = 1'b1;
    logic            loop_en = 1'b0;
    logic [DBIT-1:0] w_data  = '0;
    logic            rx;
    logic            tx;
    logic            full;
    logic            empty;
    logic [DBIT-1:0] r_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    assign rx = loop_en ? tx : rx_drv;

    uart #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR    (DVSR),
        .FIFO_W  (FIFO_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .w_data (w_data),
        .wr     (wr),
        .full   (full),
        .tx     (tx),
        .rx     (rx),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_frame(input logic [7:0] d);
        rx_drv = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DBIT; i++) begin
            rx_drv = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (SB_TICK * DVSR + 4 * DVSR) @(negedge clk);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8 && rx_q.size() > 0; i++) begin
            check({tag, "_rdata"}, r_data, rx_q.pop_front());
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
        check({tag, "_empty_after_reads"}, empty, 1);
    endtask

    task automatic wait_tx_drain(input string tag);
        int k;
        k = 0;
        while (tx_q.size() != 0 && k < 8 * FRAME_CLKS) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_tx_drained"}, tx_q.size(), 0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check({tag, "_tx_idle"}, tx, 1);
    endtask

    // Serial decoder: samples each bit near its middle and scores the byte.
    initial begin : tx_monitor
        logic [9:0] bits;
        logic       aborted;
        int         wait_n;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    wait_n = (b == 0) ? BIT_CLKS / 2 : BIT_CLKS;
                    for (int c = 0; c < wait_n && !aborted; c++) begin
                        @(negedge clk);
                        if (reset !== 1'b1) aborted = 1'b1;
                    end
                    bits[b] = tx;
                end
                if (aborted) begin
                    while (reset !== 1'b1) @(negedge clk);
                end else begin
                    check("tx_start_bit", bits[0], 0);
                    check("tx_stop_bit", bits[9], 1);
                    if (tx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got %0h, expected no frame", bits[8:1]);
                    end else begin
                        check("tx_byte", bits[8:1], tx_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 80000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t txv[6];
        vec_t rxv[5];
        int   k;

        // {data, expected full after the write, transmitted}
        txv[0] = '{data: 8'h01, exp_flag: 1'b0, kept: 1'b1};
        txv[1] = '{data: 8'h02, exp_flag: 1'b0, kept: 1'b1};
        txv[2] = '{data: 8'h03, exp_flag: 1'b0, kept: 1'b1};
        txv[3] = '{data: 8'h04, exp_flag: 1'b0, kept: 1'b1};
        txv[4] = '{data: 8'h05, exp_flag: 1'b1, kept: 1'b1};
        txv[5] = '{data: 8'h06, exp_flag: 1'b1, kept: 1'b0};
        // {data, expected empty after the frame, stored}
        rxv[0] = '{data: 8'h10, exp_flag: 1'b0, kept: 1'b1};
        rxv[1] = '{data: 8'h11, exp_flag: 1'b0, kept: 1'b1};
        rxv[2] = '{data: 8'h12, exp_flag: 1'b0, kept: 1'b1};
        rxv[3] = '{data: 8'h13, exp_flag: 1'b0, kept: 1'b1};
        rxv[4] = '{data: 8'h14, exp_flag: 1'b0, kept: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_full", full, 0);
        check("reset_empty", empty, 1);
        check("reset_rdata", r_data, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Loopback 0xA5 with TX start latency and RX arrival time
        loop_en = 1'b1;
        wr      = 1'b1;
        w_data  = 8'hA5;
        tx_q.push_back(8'hA5);
        rx_q.push_back(8'hA5);
        @(negedge clk);
        wr = 1'b0;
        check("txlat_edge1_tx", tx, 1);
        @(negedge clk);
        check("txlat_edge2_tx", tx, 1);
        @(negedge clk);
        check("txlat_edge3_tx", tx, 0);
        k = 3;
        while (empty && k < 2 * FRAME_CLKS) begin
            @(negedge clk);
            k++;
        end
        check("loop_empty_fell", empty, 0);
        check("loop_arrival_window",
              (k >= FRAME_CLKS - 2 * BIT_CLKS) && (k <= FRAME_CLKS + BIT_CLKS), 1);
        read_all("loop");
        wait_tx_drain("loop");
        loop_en = 1'b0;

        // TX overflow: back-to-back writes from idle
        for (int i = 0; i < 6; i++) begin
            wr     = 1'b1;
            w_data = txv[i].data;
            if (txv[i].kept) tx_q.push_back(txv[i].data);
            @(negedge clk);
            check($sformatf("txovf_full_%0d", i), full, txv[i].exp_flag);
        end
        wr = 1'b0;
        wait_tx_drain("txovf");
        check("txovf_full_cleared", full, 0);

        // RX overflow: five frames, no reads
        for (int i = 0; i < 5; i++) begin
            if (rxv[i].kept) rx_q.push_back(rxv[i].data);
            send_frame(rxv[i].data);
            check($sformatf("rxovf_empty_%0d", i), empty, rxv[i].exp_flag);
        end
        read_all("rxovf");

        // False start: short low pulse on rx
        rx_drv = 1'b0;
        repeat (4 * DVSR) @(negedge clk);
        rx_drv = 1'b1;
        repeat (FRAME_CLKS + BIT_CLKS) @(negedge clk);
        check("false_start_empty", empty, 1);

        // Reset mid-frame with both FIFOs occupied
        send_frame(8'h77);
        check("rst_pre_empty", empty, 0);
        for (int i = 0; i < 5; i++) begin
            wr     = 1'b1;
            w_data = 8'h5A + 8'(i);
            @(negedge clk);
        end
        wr = 1'b0;
        check("rst_pre_full", full, 1);
        repeat (3 * BIT_CLKS) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_full", full, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_rdata", r_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr     = 1'b1;
        w_data = 8'h3C;
        tx_q.push_back(8'h3C);
        @(negedge clk);
        wr = 1'b0;
        wait_tx_drain("rst_after");
        check("rst_after_empty", empty, 1);

        // Simultaneous pop and push on a full RX FIFO
        for (int i = 0; i < 4; i++) begin
            rx_q.push_back(8'h21 + 8'(i));
            send_frame(8'h21 + 8'(i));
        end
        rx_q.push_back(8'h25);
        fork
            send_frame(8'h25);
            begin
                k = 0;
                while (dut.rx_done !== 1'b1 && k < 2 * FRAME_CLKS) begin
                    @(negedge clk);
                    k++;
                end
                check("simul_done_seen", (k < 2 * FRAME_CLKS), 1);
                check("simul_head_before", r_data, rx_q.pop_front());
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                check("simul_empty", empty, 0);
            end
        join
        read_all("simul");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
